// File: rtl/gate_test_pkg.sv
// Shared types and constants for the two-input gate stimulus/check sequencer.
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_VECTORS = 4;

  // Truth tables indexed by {in_1,in_2}
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] NAND_TT = 4'b0111;

endpackage

// File: rtl/gate_vector_sequencer_settle_timer.sv
// Settle timer: loaded at the start of each vector, expires after SETTLE_CYCLES
// edges spent in the settle phase.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

  logic [3:0] r_cnt;

  // Down-counter: terminal count of zero marks the last settle edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_expire = (r_cnt == 4'd0);

endmodule

// File: rtl/gate_vector_sequencer.sv
// Drives a two-input gate through 00,01,10,11, samples its output after a
// settle time and scores it against an expected truth table.
//
// state  | meaning
// IDLE   | inputs parked at 00, waiting for start
// SETTLE | current vector held, settle timer running
// SAMPLE | next edge captures gate_out and advances or finishes
// DONE   | one-cycle done pulse, pass/err_count/result_log valid
module gate_vector_sequencer
  import gate_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  EXPECT        = AND_TT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_out,
  output logic       in_1,
  output logic       in_2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] result_log
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_idx;
  logic [1:0] r_vec;
  logic [2:0] r_err;
  logic [3:0] r_log;
  logic       r_pass;

  logic       w_tmr_load;
  logic       w_tmr_en;
  logic       w_expire;
  logic       w_mismatch;
  logic [2:0] w_err_nxt;
  logic       w_busy;
  logic       w_done;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_tmr_load),
    .i_en     (w_tmr_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // abort takes priority over start and over the sample in progress
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_en    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = ST_SETTLE;
          w_tmr_load  = 1'b1;
        end
      end
      ST_SETTLE: begin
        w_busy = 1'b1;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_en = 1'b1;
          if (w_expire) begin
            w_state_nxt = ST_SAMPLE;
          end
        end
      end
      ST_SAMPLE: begin
        w_busy = 1'b1;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SETTLE;
          w_tmr_load  = 1'b1;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_mismatch = gate_out ^ EXPECT[r_idx];
  assign w_err_nxt  = r_err + {2'b00, w_mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= 2'd0;
      r_vec  <= 2'd0;
      r_err  <= 3'd0;
      r_log  <= 4'd0;
      r_pass <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_idx  <= 2'd0;
            r_vec  <= 2'd0;
            r_err  <= 3'd0;
            r_log  <= 4'd0;
            r_pass <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            r_vec  <= 2'd0;
            r_pass <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            r_vec  <= 2'd0;
            r_pass <= 1'b0;
          end else begin
            r_log[r_idx] <= gate_out;
            r_err        <= w_err_nxt;
            if (r_idx == LAST_IDX) begin
              r_vec  <= 2'd0;
              r_pass <= (w_err_nxt == 3'd0);
            end else begin
              r_idx <= r_idx + 2'd1;
              r_vec <= r_idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_1       = r_vec[1];
  assign in_2       = r_vec[0];
  assign busy       = w_busy;
  assign done       = w_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign result_log = r_log;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench for gate_vector_sequencer: one instance with S=1 driving a
// selectable AND/OR gate model, one with S=3 driving an AND gate with glitches.
module tb_gate_vector_sequencer;
  import gate_test_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start_a, abort_a, gate_out_a;
  logic       in1_a, in2_a, busy_a, done_a, pass_a;
  logic [2:0] err_a;
  logic [3:0] log_a;
  logic       start_b, abort_b, gate_out_b;
  logic       in1_b, in2_b, busy_b, done_b, pass_b;
  logic [2:0] err_b;
  logic [3:0] log_b;
  logic       fault;
  logic       glitch;

  int errors;
  int checks;

  gate_vector_sequencer #(.SETTLE_CYCLES(1), .EXPECT(AND_TT)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .gate_out(gate_out_a),
    .in_1(in1_a), .in_2(in2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .result_log(log_a)
  );

  gate_vector_sequencer #(.SETTLE_CYCLES(3), .EXPECT(AND_TT)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .gate_out(gate_out_b),
    .in_1(in1_b), .in_2(in2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .result_log(log_b)
  );

  // Gate models: good AND, or a faulty gate behaving as OR; glitch only on b
  assign gate_out_a = fault ? (in1_a | in2_a) : (in1_a & in2_a);
  assign gate_out_b = (in1_b & in2_b) ^ glitch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({in1_a, in2_a} !== 2'b00) begin errors++; $display("FAIL reset_in got=%b exp=00", {in1_a, in2_a}); end
    checks++; if ({busy_a, done_a, pass_a} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {busy_a, done_a, pass_a}); end
    checks++; if ({err_a, log_a} !== 7'd0) begin errors++; $display("FAIL reset_err_log got=%b/%b exp=0/0", err_a, log_a); end
    checks++; if ({in1_b, in2_b, busy_b, done_b, pass_b, err_b, log_b} !== 12'd0) begin errors++; $display("FAIL reset_b got=%b exp=0", {in1_b, in2_b, busy_b, done_b, pass_b, err_b, log_b}); end
    start_a = 1'b0; start_b = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({in1_a, in2_a, busy_a, done_a, pass_a, err_a, log_a} !== 12'd0) begin errors++; $display("FAIL reset_idle got=%b exp=0", {in1_a, in2_a, busy_a, done_a, pass_a, err_a, log_a}); end
  endtask

  // Full run on instance a (sel_b=0) or b (sel_b=1); checks vector sequence,
  // busy, done timing, final results and that results hold afterwards.
  task automatic run_check(input string name, input int s, input bit sel_b,
                           input logic [3:0] exp_log, input logic [2:0] exp_err,
                           input logic exp_pass, input bit extra_starts, input bit glitch_en);
    int total;
    int done_cnt;
    int v;
    logic [1:0] vb;
    logic o_in1, o_in2, o_busy, o_done, o_pass;
    logic [2:0] o_err;
    logic [3:0] o_log;
    total = 4 * (s + 1);
    done_cnt = 0;
    @(negedge clk);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= total + 2; k++) begin
      @(negedge clk);
      o_in1  = sel_b ? in1_b  : in1_a;
      o_in2  = sel_b ? in2_b  : in2_a;
      o_busy = sel_b ? busy_b : busy_a;
      o_done = sel_b ? done_b : done_a;
      o_pass = sel_b ? pass_b : pass_a;
      o_err  = sel_b ? err_b  : err_a;
      o_log  = sel_b ? log_b  : log_a;
      v  = (k < total) ? k / (s + 1) : 0;
      vb = v[1:0];
      if (o_done) done_cnt++;
      checks++; if ({o_in1, o_in2} !== vb) begin errors++; $display("FAIL %s vec k=%0d got=%b exp=%b", name, k, {o_in1, o_in2}, vb); end
      checks++; if (o_busy !== (k < total)) begin errors++; $display("FAIL %s busy k=%0d got=%b exp=%b", name, k, o_busy, (k < total)); end
      checks++; if (o_done !== (k == total)) begin errors++; $display("FAIL %s done k=%0d got=%b exp=%b", name, k, o_done, (k == total)); end
      if (k == total || k == total + 2) begin
        checks++; if (o_log !== exp_log) begin errors++; $display("FAIL %s log k=%0d got=%b exp=%b", name, k, o_log, exp_log); end
        checks++; if (o_err !== exp_err) begin errors++; $display("FAIL %s err k=%0d got=%0d exp=%0d", name, k, o_err, exp_err); end
        checks++; if (o_pass !== exp_pass) begin errors++; $display("FAIL %s pass k=%0d got=%b exp=%b", name, k, o_pass, exp_pass); end
      end
      // drive for edge E0+k+1
      if (sel_b) start_b = extra_starts && (k + 1 == 2 || k + 1 == 5);
      else       start_a = extra_starts && (k + 1 == 2 || k + 1 == 5);
      glitch = glitch_en && (k + 1 == 6);
    end
    glitch = 1'b0;
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s done_count got=%0d exp=1", name, done_cnt); end
  endtask

  task automatic test_and_gate();
    fault = 1'b0;
    run_check("and_gate", 1, 1'b0, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_faulty_gate();
    fault = 1'b1;
    run_check("faulty_gate", 1, 1'b0, 4'b1110, 3'd2, 1'b0, 1'b0, 1'b0);
    fault = 1'b0;
  endtask

  task automatic test_start_ignored();
    run_check("start_ignored", 1, 1'b0, 4'b1000, 3'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    int done_cnt;
    done_cnt = 0;
    fault = 1'b1;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    @(negedge clk); abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
    checks++; if ({in1_a, in2_a} !== 2'b00) begin errors++; $display("FAIL abort_in got=%b exp=00", {in1_a, in2_a}); end
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL abort_pass got=%b exp=0", pass_a); end
    checks++; if (err_a !== 3'd0) begin errors++; $display("FAIL abort_err got=%0d exp=0", err_a); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_a) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_start_same got=%b exp=0", busy_a); end
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_start_after got=%b exp=0", busy_a); end
    fault = 1'b0;
  endtask

  task automatic test_async_reset();
    fault = 1'b1;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if ({in1_a, in2_a} !== 2'b10) begin errors++; $display("FAIL async_pre_in got=%b exp=10", {in1_a, in2_a}); end
    checks++; if ({err_a, log_a} !== {3'd1, 4'b0010}) begin errors++; $display("FAIL async_pre_err_log got=%0d/%b exp=1/0010", err_a, log_a); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({in1_a, in2_a, busy_a} !== 3'b000) begin errors++; $display("FAIL async_in_busy got=%b exp=000", {in1_a, in2_a, busy_a}); end
    checks++; if ({err_a, log_a, pass_a} !== 8'd0) begin errors++; $display("FAIL async_results got=%b exp=0", {err_a, log_a, pass_a}); end
    @(negedge clk); rst_n = 1'b1; fault = 1'b0;
    run_check("after_reset", 1, 1'b0, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_glitch_s3();
    run_check("glitch_s3", 3, 1'b1, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    errors = 0; checks = 0;
    fault = 1'b0; glitch = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    rst_n = 1'b1;
    #2;
    test_reset();
    test_and_gate();
    test_faulty_gate();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_glitch_s3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
